// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional misaligned-redirect trap is enabled with IF_MISALIGN_CHK_EN.
package if_fetch_pkg;

    localparam int unsigned InstAddrW = 32;
    localparam int unsigned InstW     = 32;
    localparam int unsigned ByteW     = 8;

    typedef logic [InstAddrW-1:0] inst_addr_bus_t;
    typedef logic [InstW-1:0]     inst_bus_t;
    typedef logic [ByteW-1:0]     mem_byte_t;

    localparam inst_bus_t ZeroWord = 32'h0000_0000;
    localparam inst_bus_t NopInst  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IfFetch = 2'd0,
        IfDrain = 2'd1,
        IfHold  = 2'd2
    } if_state_e;

    // Payload presented to the IF/ID pipeline register.
    typedef struct packed {
        inst_addr_bus_t pc;
        inst_bus_t      inst;
    } if_payload_t;

    // Little-endian byte lane insert.
    function automatic inst_bus_t put_byte(input inst_bus_t word,
                                           input logic [1:0] idx,
                                           input mem_byte_t  b);
        inst_bus_t w;
        w = word;
        unique case (idx)
            2'd0: w[7:0]   = b;
            2'd1: w[15:8]  = b;
            2'd2: w[23:16] = b;
            2'd3: w[31:24] = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: byte-serial memory reads assembled into 32-bit words,
// valid/ready output, redirect with drain. Macro IF_MISALIGN_CHK_EN adds if_misalign.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter inst_addr_bus_t RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    output logic           mem_req,
    output inst_addr_bus_t mem_addr,
    input  logic           mem_ack,
    input  mem_byte_t      mem_rdata,
    output logic           if_valid,
    output inst_addr_bus_t if_pc,
    output inst_bus_t      if_inst,
    input  logic           id_ready,
    input  logic           br_taken,
    input  inst_addr_bus_t br_target
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic           if_misalign
`endif
);

    if_state_e      state_q, state_d;
    inst_addr_bus_t pc_q, pc_d;
    logic [1:0]     k_q, k_d;
    inst_bus_t      buf_q, buf_d;
    logic           mem_req_q, mem_req_d;
    inst_addr_bus_t mem_addr_q, mem_addr_d;
    logic           if_valid_q, if_valid_d;
    if_payload_t    if_out_q, if_out_d;
`ifdef IF_MISALIGN_CHK_EN
    logic           misalign_q, misalign_d;
`endif

    logic           req_pending_c;
    logic           launch_c;
    inst_addr_bus_t launch_pc_c;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        k_d         = k_q;
        buf_d       = buf_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        if_valid_d  = if_valid_q;
        if_out_d    = if_out_q;
`ifdef IF_MISALIGN_CHK_EN
        misalign_d  = misalign_q;
`endif
        launch_c    = 1'b0;
        launch_pc_c = pc_q;

        req_pending_c = mem_req_q && !mem_ack;

        unique case (state_q)
            IfFetch: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q + InstAddrW'(k_q);
                end else if (mem_ack) begin
                    if (k_q == 2'd3) begin
                        if_out_d.inst = put_byte(buf_q, 2'd3, mem_rdata);
                        if_out_d.pc   = pc_q;
                        if_valid_d    = 1'b1;
                        mem_req_d     = 1'b0;
                        k_d           = 2'd0;
                        state_d       = IfHold;
                    end else begin
                        buf_d      = put_byte(buf_q, k_q, mem_rdata);
                        k_d        = k_q + 2'd1;
                        mem_addr_d = pc_q + InstAddrW'(k_q) + InstAddrW'(1);
                    end
                end
            end
            IfDrain: begin
                // Abandoned request completes; its data is dropped.
                if (mem_ack) begin
                    launch_c    = 1'b1;
                    launch_pc_c = pc_q;
                end
            end
            IfHold: begin
                if (if_valid_q && id_ready) begin
                    pc_d       = pc_q + InstAddrW'(4);
                    if_valid_d = 1'b0;
                    k_d        = 2'd0;
                    buf_d      = ZeroWord;
                    state_d    = IfFetch;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q + InstAddrW'(4);
`ifdef IF_MISALIGN_CHK_EN
                    misalign_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d   = IfFetch;
                mem_req_d = 1'b0;
            end
        endcase

        // Redirect overrides every state; an unacknowledged request must drain first.
        if (br_taken) begin
            pc_d       = br_target;
            k_d        = 2'd0;
            buf_d      = ZeroWord;
            if_valid_d = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
            misalign_d = 1'b0;
`endif
            if (req_pending_c) begin
                state_d    = IfDrain;
                mem_req_d  = 1'b1;
                mem_addr_d = mem_addr_q;
                launch_c   = 1'b0;
            end else begin
                launch_c    = 1'b1;
                launch_pc_c = br_target;
            end
        end

        if (launch_c) begin
            k_d        = 2'd0;
            buf_d      = ZeroWord;
            state_d    = IfFetch;
            mem_req_d  = 1'b1;
            mem_addr_d = launch_pc_c;
`ifdef IF_MISALIGN_CHK_EN
            // Misaligned target: present a NOP with the flag instead of fetching.
            if (launch_pc_c[1:0] != 2'b00) begin
                state_d       = IfHold;
                mem_req_d     = 1'b0;
                mem_addr_d    = mem_addr_q;
                if_valid_d    = 1'b1;
                if_out_d.pc   = launch_pc_c;
                if_out_d.inst = NopInst;
                misalign_d    = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IfFetch;
            pc_q       <= RESET_PC;
            k_q        <= 2'd0;
            buf_q      <= ZeroWord;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            if_valid_q <= 1'b0;
            if_out_q   <= '{pc: RESET_PC, inst: ZeroWord};
`ifdef IF_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            k_q        <= k_d;
            buf_q      <= buf_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            if_valid_q <= if_valid_d;
            if_out_q   <= if_out_d;
`ifdef IF_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign if_valid = if_valid_q;
    assign if_pc    = if_out_q.pc;
    assign if_inst  = if_out_q.inst;
`ifdef IF_MISALIGN_CHK_EN
    assign if_misalign = misalign_q;
`endif

endmodule
